// File: rtl/ddr_host_frontend.sv
// ddr_host_frontend
// Host-side responder for the DDR controller request interface. Host requests
// are queued in a small command FIFO for the scheduler. Read returns are passed
// back to the host one cycle later. A shadow timing configuration is updated by
// mode-register writes, and those writes are applied only once the command
// queue and all outstanding reads have drained.
module ddr_host_frontend #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              CK_t,
   input  logic              RESET_n,
   input  logic [2:0]        request,
   input  logic [ADDR_W-1:0] log_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              cmd_rdy,
   input  logic              mrs_update,
   input  logic [2:0]        CL,
   input  logic [2:0]        AL,
   input  logic [2:0]        BL,
   input  logic [2:0]        CWL,
   input  logic              RD_PRE,
   input  logic              WR_PRE,
   output logic [2:0]        cfg_CL,
   output logic [2:0]        cfg_AL,
   output logic [2:0]        cfg_BL,
   output logic [2:0]        cfg_CWL,
   output logic              cfg_RD_PRE,
   output logic              cfg_WR_PRE,
   output logic              mrs_done,
   output logic              cmd_err,
   output logic              ctrl_valid,
   input  logic              ctrl_ready,
   output logic              ctrl_wr,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [DATA_W-1:0] ctrl_wdata,
   input  logic              ctrl_rvalid,
   input  logic [DATA_W-1:0] ctrl_rdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 2;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;
   typedef logic [OW-1:0] ocnt_t;

   localparam cnt_t  FULL_CNT = cnt_t'(DEPTH);
   localparam cnt_t  CNT_ONE  = cnt_t'(1);
   localparam ptr_t  PTR_ONE  = ptr_t'(1);
   localparam ocnt_t OCNT_ONE = ocnt_t'(1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t state;

   // command FIFO storage (data only, never reset)
   logic              fifo_wr    [DEPTH];
   logic [ADDR_W-1:0] fifo_addr  [DEPTH];
   logic [DATA_W-1:0] fifo_wdata [DEPTH];

   ptr_t  wr_ptr;
   ptr_t  rd_ptr;
   cnt_t  count;
   ocnt_t outst;

   // staged mode-register values waiting for the drained apply
   logic [2:0] stg_cl;
   logic [2:0] stg_al;
   logic [2:0] stg_bl;
   logic [2:0] stg_cwl;
   logic       stg_rd_pre;
   logic       stg_wr_pre;

   logic full;
   logic req_legal;
   logic req_illegal;
   logic push;
   logic pop;
   logic rd_pop;
   logic rd_ret;
   logic rd_spurious;
   logic drained;

   // Acceptance is blocked outside RUN and when full; a pop in the same cycle
   // never frees a slot for the concurrent request.
   assign full        = (count == FULL_CNT);
   assign cmd_rdy     = RESET_n && (state == RUN) && !full;
   assign req_legal   = (request == 3'd1) || (request == 3'd2);
   assign req_illegal = (request >= 3'd3);
   assign push        = cmd_rdy && req_legal;

   assign ctrl_valid  = (count != '0);
   assign pop         = ctrl_valid && ctrl_ready;
   assign ctrl_wr     = fifo_wr[rd_ptr];
   assign ctrl_addr   = fifo_addr[rd_ptr];
   assign ctrl_wdata  = fifo_wdata[rd_ptr];

   assign rd_pop      = pop && !ctrl_wr;
   assign rd_ret      = ctrl_rvalid && (outst != '0);
   assign rd_spurious = ctrl_rvalid && (outst == '0);
   assign drained     = !ctrl_valid && (outst == '0);

   // write accepted requests into the slot at the tail pointer
   always_ff @(posedge CK_t) begin
      if (push) begin
         fifo_wr[wr_ptr]    <= (request == 3'd2);
         fifo_addr[wr_ptr]  <= log_addr;
         fifo_wdata[wr_ptr] <= wr_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CK_t or negedge RESET_n) begin
      if (!RESET_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // reads issued to the scheduler whose data has not yet come back
   always_ff @(posedge CK_t or negedge RESET_n) begin
      if (!RESET_n) begin
         outst <= '0;
      end else begin
         case ({rd_pop, rd_ret})
            2'b10:   outst <= outst + OCNT_ONE;
            2'b01:   outst <= outst - OCNT_ONE;
            default: outst <= outst;
         endcase
      end
   end

   // read return register toward the host and the error pulse
   always_ff @(posedge CK_t or negedge RESET_n) begin
      if (!RESET_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         cmd_err  <= 1'b0;
      end else begin
         rd_valid <= rd_ret;
         if (rd_ret) rd_data <= ctrl_rdata;
         cmd_err  <= (cmd_rdy && req_illegal) || rd_spurious;
      end
   end

   // mode-register FSM: stage, wait for drain, apply for one cycle
   always_ff @(posedge CK_t or negedge RESET_n) begin
      if (!RESET_n) begin
         state      <= RUN;
         mrs_done   <= 1'b0;
         stg_cl     <= '0;
         stg_al     <= '0;
         stg_bl     <= '0;
         stg_cwl    <= '0;
         stg_rd_pre <= 1'b0;
         stg_wr_pre <= 1'b0;
         cfg_CL     <= '0;
         cfg_AL     <= '0;
         cfg_BL     <= '0;
         cfg_CWL    <= '0;
         cfg_RD_PRE <= 1'b0;
         cfg_WR_PRE <= 1'b0;
      end else begin
         mrs_done <= 1'b0;
         case (state)
            RUN: begin
               if (mrs_update) begin
                  stg_cl     <= CL;
                  stg_al     <= AL;
                  stg_bl     <= BL;
                  stg_cwl    <= CWL;
                  stg_rd_pre <= RD_PRE;
                  stg_wr_pre <= WR_PRE;
                  state      <= DRAIN;
               end
            end
            DRAIN: begin
               if (mrs_update) begin
                  stg_cl     <= CL;
                  stg_al     <= AL;
                  stg_bl     <= BL;
                  stg_cwl    <= CWL;
                  stg_rd_pre <= RD_PRE;
                  stg_wr_pre <= WR_PRE;
               end
               if (drained) state <= APPLY;
            end
            APPLY: begin
               cfg_CL     <= stg_cl;
               cfg_AL     <= stg_al;
               cfg_BL     <= stg_bl;
               cfg_CWL    <= stg_cwl;
               cfg_RD_PRE <= stg_rd_pre;
               cfg_WR_PRE <= stg_wr_pre;
               mrs_done   <= 1'b1;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
